// File: rtl/evm_pkg.sv
// Shared types and sizing for the three-candidate voting machine.
package evm_pkg;

    typedef enum logic {
        VOTING = 1'b0,
        CLOSED = 1'b1
    } evm_state_t;

    localparam int NUM_CAND      = 3;
    localparam int DEFAULT_CNT_W = 32;

endpackage

// File: rtl/evm_vote_edge_detect.sv
// Turns a debounced button level into a one-cycle press strobe on its rising edge.
module vote_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic prev;

    // History keeps updating in every state so a held button never re-counts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev <= 1'b0;
        end else begin
            prev <= btn;
        end
    end

    assign press = btn & ~prev;

endmodule

// File: rtl/evm.sv
// Voting machine core: one vote per press, tallies hidden until polling closes.
module evm
    import evm_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             rst,
    input  logic             clk,
    input  logic             cand1,
    input  logic             cand2,
    input  logic             cand3,
    output logic [CNT_W-1:0] rcnt1,
    output logic [CNT_W-1:0] rcnt2,
    output logic [CNT_W-1:0] rcnt3,
    input  logic             voting_over
);

    logic [NUM_CAND-1:0] btn;
    logic [NUM_CAND-1:0] press;
    evm_state_t          state;
    evm_state_t          state_next;
    logic                one_hot;
    logic                count_en;
    logic [CNT_W-1:0]    cnt [NUM_CAND];

    assign btn = {cand3, cand2, cand1};

    for (genvar i = 0; i < NUM_CAND; i++) begin : g_edge
        vote_edge_detect u_edge (
            .clk   (clk),
            .rst   (rst),
            .btn   (btn[i]),
            .press (press[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= VOTING;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == VOTING && voting_over) begin
            state_next = CLOSED;
        end
    end

    // Simultaneous presses are ambiguous and dropped; the close cycle also drops votes.
    assign one_hot  = (press != '0) && ((press & (press - NUM_CAND'(1))) == '0);
    assign count_en = (state == VOTING) && !voting_over && one_hot;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                cnt[i] <= '0;
            end
        end else if (count_en) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (press[i] && cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Keyed on state_next so results appear on the same edge that closes polling.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rcnt1 <= '0;
            rcnt2 <= '0;
            rcnt3 <= '0;
        end else if (state_next == CLOSED) begin
            rcnt1 <= cnt[0];
            rcnt2 <= cnt[1];
            rcnt3 <= cnt[2];
        end else begin
            rcnt1 <= '0;
            rcnt2 <= '0;
            rcnt3 <= '0;
        end
    end

endmodule

// File: tb/tb_evm.sv
// Directed bench for evm: a 32-bit and a 4-bit instance see identical stimulus.
module tb_evm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cand1 = 1'b0;
    logic        cand2 = 1'b0;
    logic        cand3 = 1'b0;
    logic        voting_over = 1'b0;
    logic [31:0] w1, w2, w3;
    logic [3:0]  n1, n2, n3;
    int          checks = 0;
    int          errors = 0;

    evm u_dut32 (
        .rst         (rst),
        .clk         (clk),
        .cand1       (cand1),
        .cand2       (cand2),
        .cand3       (cand3),
        .rcnt1       (w1),
        .rcnt2       (w2),
        .rcnt3       (w3),
        .voting_over (voting_over)
    );

    evm #(.CNT_W(4)) u_dut4 (
        .rst         (rst),
        .clk         (clk),
        .cand1       (cand1),
        .cand2       (cand2),
        .cand3       (cand3),
        .rcnt1       (n1),
        .rcnt2       (n2),
        .rcnt3       (n3),
        .voting_over (voting_over)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c1, input logic c2, input logic c3,
                                 input logic vo);
        cand1       = c1;
        cand2       = c2;
        cand3       = c3;
        voting_over = vo;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] sat4(input logic [31:0] v);
        return (v > 32'd15) ? 32'd15 : v;
    endfunction

    task automatic checkAll(input string tag, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
        checkOutput({tag, " w.rcnt1"}, w1, e1);
        checkOutput({tag, " w.rcnt2"}, w2, e2);
        checkOutput({tag, " w.rcnt3"}, w3, e3);
        checkOutput({tag, " n.rcnt1"}, {28'd0, n1}, sat4(e1));
        checkOutput({tag, " n.rcnt2"}, {28'd0, n2}, sat4(e2));
        checkOutput({tag, " n.rcnt3"}, {28'd0, n3}, sat4(e3));
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0);
        rst = 1'b1;
    endtask

    initial begin
        // Test 1: reset held two cycles
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkAll("reset", 0, 0, 0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkAll("post-reset", 0, 0, 0);

        // Test 2: basic pulses, tallies hidden until close
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkAll("hidden", 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkAll("hidden2", 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkAll("close basic", 2, 1, 1);

        // Test 3: held button counts once
        doReset();
        applyStimulus(0, 0, 0, 0);
        checkAll("reset after close", 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkAll("held", 0, 1, 0);

        // Test 4: simultaneous press invalid, held remnant ignored, close-cycle press dropped
        doReset();
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1);
        checkAll("invalid pair", 0, 0, 1);

        // Test 5: presses after close ignored, close sticky, reset clears
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 1);
            applyStimulus(0, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0);
        checkAll("sticky close", 0, 0, 1);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1);
        checkAll("reset over close", 0, 0, 0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0);
        checkAll("voting again", 0, 0, 0);

        // Test 6: saturation in the 4-bit build, 32-bit build keeps counting
        doReset();
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 0, 0);
            applyStimulus(0, 0, 0, 0);
        end
        checkAll("sat hidden", 0, 0, 0);
        applyStimulus(0, 0, 0, 1);
        checkAll("saturate", 16, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
